// File: rtl/xgpio_pkg.sv
// rtl/xgpio_pkg.sv - register map, edge modes and lane-merge helper for xgpio
package xgpio_pkg;

  // Register index, taken from addr[1:0]
  localparam logic [1:0] XGPIO_DATA  = 2'd0;
  localparam logic [1:0] XGPIO_DIR   = 2'd1;
  localparam logic [1:0] XGPIO_IFLAG = 2'd2;
  localparam logic [1:0] XGPIO_IMASK = 2'd3;

  // Interrupt edge selection
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Replace the byte lanes whose write enable is set, keep the others.
  function automatic logic [15:0] lane_merge(
    input logic [15:0] old_v,
    input logic [15:0] wr_v,
    input logic        ud_ce,
    input logic        ld_ce
  );
    logic [15:0] m;
    m = {{8{ud_ce}}, {8{ld_ce}}};
    return (old_v & ~m) | (wr_v & m);
  endfunction

endpackage

// File: rtl/ctrl_dec.sv
// rtl/ctrl_dec.sv - XSOC control bus decoder shared by all peripherals
//
// Purpose: turns the abstract control bus plus peripheral select into
// per-lane read tristate controls, per-lane write clock enables and the
// register address.
// Ports:
//   i_ctrl   16  abstract control bus: [4:0] addr, [8] read high lane,
//                [9] read low lane, [10] write high lane, [11] write low lane
//   i_sel     1  peripheral select
//   o_ud_t    1  high lane tristate (1 = release d[15:8])
//   o_ld_t    1  low lane tristate (1 = release d[7:0])
//   o_ud_ce   1  high lane write enable
//   o_ld_ce   1  low lane write enable
//   o_addr    5  register address
module ctrl_dec (
  input  logic [15:0] i_ctrl,
  input  logic        i_sel,
  output logic        o_ud_t,
  output logic        o_ld_t,
  output logic        o_ud_ce,
  output logic        o_ld_ce,
  output logic [4:0]  o_addr
);

  logic w_unused;

  assign o_addr  = i_ctrl[4:0];
  assign o_ud_t  = ~(i_sel & i_ctrl[8]);
  assign o_ld_t  = ~(i_sel & i_ctrl[9]);
  assign o_ud_ce = i_sel & i_ctrl[10];
  assign o_ld_ce = i_sel & i_ctrl[11];

  // Reserved control bits carry no meaning for this decoder.
  assign w_unused = ^{i_ctrl[15:12], i_ctrl[7:5]};

endmodule

// File: rtl/xgpio_sync.sv
// rtl/xgpio_sync.sv - pad input synchroniser with previous-value edge detect
//
// Purpose: brings asynchronous pad inputs into the clock domain through a
// SYNC-deep flop chain and flags rising/falling transitions of the
// synchronised value against its value one cycle earlier.
// Ports:
//   i_clk     1  clock
//   i_rst     1  synchronous active-high reset
//   i_pin     W  asynchronous pad inputs
//   o_sync_q  W  synchronised pin values
//   o_rise    W  sync_q & ~prev
//   o_fall    W  ~sync_q & prev
module xgpio_sync #(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_pin,
  output logic [W-1:0] o_sync_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_chain [SYNC];
  logic [W-1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC; k++) begin
        r_chain[k] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_chain[0] <= i_pin;
      for (int k = 1; k < SYNC; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
      r_prev <= r_chain[SYNC-1];
    end
  end

  assign o_sync_q = r_chain[SYNC-1];
  assign o_rise   = r_chain[SYNC-1] & ~r_prev;
  assign o_fall   = ~r_chain[SYNC-1] & r_prev;

endmodule

// File: rtl/xgpio.sv
// rtl/xgpio.sv - parametrised bidirectional GPIO with edge interrupts
//
// Purpose: per-bit direction, output latch, synchronised input sampling and
// sticky edge interrupt flags with mask, on the XSOC control bus.
// Ports:
//   clk     1   clock
//   rst     1   synchronous active-high reset
//   ctrl    16  abstract control bus (decoded by ctrl_dec)
//   sel     1   peripheral select
//   d       16  data bus, driven only while this peripheral is read
//   pin_i   W   pad inputs, asynchronous
//   pin_o   W   output latch
//   pin_oe  W   direction register, 1 = output
//   irq     1   registered |(iflag & imask)
module xgpio
  import xgpio_pkg::*;
#(
  parameter int           W       = 8,
  parameter int           SYNC    = 2,
  parameter int           EDGE    = 0,
  parameter logic [W-1:0] RST_OUT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  ctrl,
  input  logic         sel,
  inout  wire  [15:0]  d,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] pin_o,
  output logic [W-1:0] pin_oe,
  output logic         irq
);

  localparam int              CW      = $clog2(SYNC + 2);
  localparam logic [CW-1:0]   ARM_CNT = CW'(SYNC + 1);

  logic          w_ud_t, w_ld_t, w_ud_ce, w_ld_ce;
  logic [4:0]    w_addr;
  logic [1:0]    w_idx;
  logic [W-1:0]  w_sync_q, w_rise, w_fall, w_ev;
  logic          w_armed;
  logic [15:0]   w_sync16, w_out16, w_dir16, w_iflag16, w_imask16;
  logic [15:0]   w_out_nxt16, w_dir_nxt16, w_imask_nxt16, w_clr16;
  logic [W-1:0]  w_iflag_nxt;
  logic [15:0]   w_rdata;
  logic          w_unused;

  logic [W-1:0]  r_out, r_dir, r_iflag, r_imask;
  logic          r_irq;
  logic [CW-1:0] r_cnt;

  ctrl_dec u_ctrl_dec (
    .i_ctrl  (ctrl),
    .i_sel   (sel),
    .o_ud_t  (w_ud_t),
    .o_ld_t  (w_ld_t),
    .o_ud_ce (w_ud_ce),
    .o_ld_ce (w_ld_ce),
    .o_addr  (w_addr)
  );

  xgpio_sync #(.W(W), .SYNC(SYNC)) u_sync (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pin    (pin_i),
    .o_sync_q (w_sync_q),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  // addr[4:2] alias the four registers.
  assign w_idx = w_addr[1:0];

  assign w_ev = (EDGE == EDGE_RISE) ? w_rise :
                (EDGE == EDGE_FALL) ? w_fall : (w_rise | w_fall);

  // The synchroniser and prev register need SYNC+1 clocks after reset before
  // rise/fall compare two real samples; until then edges are ignored.
  assign w_armed = (r_cnt == ARM_CNT);

  // Zero-extend W-bit state onto the 16-bit bus so unused bits read as 0.
  always_comb begin
    w_sync16  = '0;
    w_out16   = '0;
    w_dir16   = '0;
    w_iflag16 = '0;
    w_imask16 = '0;
    w_sync16[W-1:0]  = w_sync_q;
    w_out16[W-1:0]   = r_out;
    w_dir16[W-1:0]   = r_dir;
    w_iflag16[W-1:0] = r_iflag;
    w_imask16[W-1:0] = r_imask;
  end

  assign w_out_nxt16   = lane_merge(w_out16, d,
                                    w_ud_ce & (w_idx == XGPIO_DATA),
                                    w_ld_ce & (w_idx == XGPIO_DATA));
  assign w_dir_nxt16   = lane_merge(w_dir16, d,
                                    w_ud_ce & (w_idx == XGPIO_DIR),
                                    w_ld_ce & (w_idx == XGPIO_DIR));
  assign w_imask_nxt16 = lane_merge(w_imask16, d,
                                    w_ud_ce & (w_idx == XGPIO_IMASK),
                                    w_ld_ce & (w_idx == XGPIO_IMASK));
  assign w_clr16       = lane_merge(16'h0000, d,
                                    w_ud_ce & (w_idx == XGPIO_IFLAG),
                                    w_ld_ce & (w_idx == XGPIO_IFLAG));

  // Set term is ORed after the clear so a same-cycle edge survives W1C.
  assign w_iflag_nxt = (r_iflag & ~w_clr16[W-1:0]) | (w_ev & {W{w_armed}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= RST_OUT;
      r_dir   <= '0;
      r_iflag <= '0;
      r_imask <= '0;
      r_irq   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_out   <= w_out_nxt16[W-1:0];
      r_dir   <= w_dir_nxt16[W-1:0];
      r_iflag <= w_iflag_nxt;
      r_imask <= w_imask_nxt16[W-1:0];
      r_irq   <= |(r_iflag & r_imask);
      if (!w_armed) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (w_idx)
      XGPIO_DATA:  w_rdata = w_sync16;
      XGPIO_DIR:   w_rdata = w_dir16;
      XGPIO_IFLAG: w_rdata = w_iflag16;
      XGPIO_IMASK: w_rdata = w_imask16;
      default:     w_rdata = 16'h0000;
    endcase
  end

  assign d[7:0]  = w_ld_t ? 8'hzz : w_rdata[7:0];
  assign d[15:8] = w_ud_t ? 8'hzz : w_rdata[15:8];

  assign pin_o  = r_out;
  assign pin_oe = r_dir;
  assign irq    = r_irq;

  // Alias address bits and bus bits above W have no destination.
  assign w_unused = ^{w_addr, w_out_nxt16, w_dir_nxt16, w_imask_nxt16, w_clr16};

endmodule

// File: tb/tb_xgpio.sv
// tb/tb_xgpio.sv - directed self-checking bench for xgpio
module tb_xgpio;
  import xgpio_pkg::*;

  localparam logic [15:0] RD_UD = 16'h0100;
  localparam logic [15:0] RD_LD = 16'h0200;
  localparam logic [15:0] WR_UD = 16'h0400;
  localparam logic [15:0] WR_LD = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl;
  logic        sel8, sel16;
  logic [7:0]  pin8;
  logic [15:0] pin16;
  wire  [15:0] d8, d16;
  logic        drv8, drv16;
  logic [15:0] dv8, dv16;
  logic [7:0]  po8, poe8;
  logic [15:0] po16, poe16;
  logic        irq8, irq16;
  int          n_checks = 0;
  int          n_fail   = 0;

  assign d8  = drv8  ? dv8  : 16'hzzzz;
  assign d16 = drv16 ? dv16 : 16'hzzzz;

  always #10 clk = ~clk;

  xgpio #(.W(8), .SYNC(2), .EDGE(0), .RST_OUT(8'h81)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .ctrl   (ctrl),
    .sel    (sel8),
    .d      (d8),
    .pin_i  (pin8),
    .pin_o  (po8),
    .pin_oe (poe8),
    .irq    (irq8)
  );

  xgpio #(.W(16), .SYNC(3), .EDGE(2), .RST_OUT(16'hBEEF)) u_dut16 (
    .clk    (clk),
    .rst    (rst),
    .ctrl   (ctrl),
    .sel    (sel16),
    .d      (d16),
    .pin_i  (pin16),
    .pin_o  (po16),
    .pin_oe (poe16),
    .irq    (irq16)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit u16, input logic [15:0] lanes, input logic [1:0] idx,
                    input logic [15:0] val);
    ctrl = lanes | {14'h0, idx};
    if (u16) begin
      sel16 = 1'b1; drv16 = 1'b1; dv16 = val;
    end else begin
      sel8 = 1'b1; drv8 = 1'b1; dv8 = val;
    end
    @(negedge clk);
    ctrl = '0; sel8 = 1'b0; sel16 = 1'b0; drv8 = 1'b0; drv16 = 1'b0;
  endtask

  task automatic chk_rd(input bit u16, input logic [1:0] idx, input logic [15:0] exp,
                        input string tag);
    logic [15:0] v;
    ctrl = RD_UD | RD_LD | {14'h0, idx};
    if (u16) sel16 = 1'b1; else sel8 = 1'b1;
    #1;
    v = u16 ? d16 : d8;
    ctrl = '0; sel8 = 1'b0; sel16 = 1'b0;
    check(tag, v, exp);
  endtask

  initial begin
    rst = 1'b1; ctrl = '0; sel8 = 1'b0; sel16 = 1'b0;
    pin8 = '0; pin16 = '0; drv8 = 1'b0; drv16 = 1'b0; dv8 = '0; dv16 = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    chk_rd(0, XGPIO_DATA,  16'h0000, "rst_data");
    chk_rd(0, XGPIO_DIR,   16'h0000, "rst_dir");
    chk_rd(0, XGPIO_IFLAG, 16'h0000, "rst_iflag");
    chk_rd(0, XGPIO_IMASK, 16'h0000, "rst_imask");
    check("rst_pin_oe", {8'h00, poe8}, 16'h0000);
    check("rst_pin_o",  {8'h00, po8},  16'h0081);
    check("rst_irq",    {15'h0, irq8}, 16'h0000);
    check("rst16_pin_o", po16, 16'hBEEF);

    // Direction, output latch, input sampling latency
    wr(0, WR_UD | WR_LD, XGPIO_DIR,  16'hFFF0);
    wr(0, WR_UD | WR_LD, XGPIO_DATA, 16'h00A5);
    check("dir_pin_oe", {8'h00, poe8}, 16'h00F0);
    check("data_pin_o", {8'h00, po8},  16'h00A5);
    chk_rd(0, XGPIO_DIR, 16'h00F0, "dir_hi_zero");
    pin8 = 8'h3C;
    chk_rd(0, XGPIO_DATA, 16'h0000, "data_lat0");
    tick(1);
    chk_rd(0, XGPIO_DATA, 16'h0000, "data_lat1");
    tick(1);
    chk_rd(0, XGPIO_DATA, 16'h003C, "data_lat2");

    // Unselected peripheral leaves the bus to the other driver
    ctrl = RD_UD | RD_LD; sel8 = 1'b0; drv8 = 1'b1; dv8 = 16'h0000;
    #1;
    check("float", d8, 16'h0000);
    drv8 = 1'b0; ctrl = '0;

    tick(1);
    chk_rd(0, XGPIO_IFLAG, 16'h003C, "iflag_rise_multi");
    wr(0, WR_UD | WR_LD, XGPIO_IFLAG, 16'h0004);
    chk_rd(0, XGPIO_IFLAG, 16'h0038, "w1c_partial");
    wr(0, WR_UD | WR_LD, XGPIO_IFLAG, 16'h00FF);
    chk_rd(0, XGPIO_IFLAG, 16'h0000, "w1c_all");

    // Rising edge flag and irq latency
    wr(0, WR_UD | WR_LD, XGPIO_IMASK, 16'h0001);
    chk_rd(0, XGPIO_IMASK, 16'h0001, "imask_rd");
    pin8 = 8'h3D;
    tick(2);
    chk_rd(0, XGPIO_IFLAG, 16'h0000, "iflag_lat2");
    tick(1);
    chk_rd(0, XGPIO_IFLAG, 16'h0001, "iflag_lat3");
    check("irq_lat3", {15'h0, irq8}, 16'h0000);
    tick(1);
    check("irq_lat4", {15'h0, irq8}, 16'h0001);
    pin8 = 8'h3C;
    tick(4);
    chk_rd(0, XGPIO_IFLAG, 16'h0001, "no_fall_flag");

    // Mask write reaches irq one cycle later
    wr(0, WR_UD | WR_LD, XGPIO_IMASK, 16'h0000);
    check("irq_mask_old", {15'h0, irq8}, 16'h0001);
    tick(1);
    check("irq_mask_off", {15'h0, irq8}, 16'h0000);
    wr(0, WR_UD | WR_LD, XGPIO_IMASK, 16'h0001);
    tick(1);
    check("irq_mask_on", {15'h0, irq8}, 16'h0001);

    // Edge and W1C on the same clock: set wins
    pin8 = 8'h3D;
    tick(2);
    wr(0, WR_UD | WR_LD, XGPIO_IFLAG, 16'h0001);
    chk_rd(0, XGPIO_IFLAG, 16'h0001, "set_wins");
    wr(0, WR_UD | WR_LD, XGPIO_IFLAG, 16'h0001);
    chk_rd(0, XGPIO_IFLAG, 16'h0000, "w1c_clear");
    tick(1);
    check("irq_clear", {15'h0, irq8}, 16'h0000);

    // Mid-run reset with a concurrent write
    pin8 = 8'h00;
    tick(4);
    pin8 = 8'h0F;
    tick(4);
    chk_rd(0, XGPIO_IFLAG, 16'h000F, "iflag_0f");
    wr(0, WR_UD | WR_LD, XGPIO_IMASK, 16'h00FF);
    wr(0, WR_UD | WR_LD, XGPIO_DIR,   16'h00FF);
    tick(1);
    check("irq_pre_rst", {15'h0, irq8}, 16'h0001);
    rst = 1'b1; pin8 = 8'hFF;
    ctrl = WR_UD | WR_LD | {14'h0, XGPIO_DATA}; sel8 = 1'b1; drv8 = 1'b1; dv8 = 16'h0077;
    @(negedge clk);
    ctrl = '0; sel8 = 1'b0; drv8 = 1'b0;
    check("mid_rst_pin_o",  {8'h00, po8},  16'h0081);
    check("mid_rst_pin_oe", {8'h00, poe8}, 16'h0000);
    check("mid_rst_irq",    {15'h0, irq8}, 16'h0000);
    chk_rd(0, XGPIO_IFLAG, 16'h0000, "mid_rst_iflag");
    chk_rd(0, XGPIO_IMASK, 16'h0000, "mid_rst_imask");
    check("mid_rst16_pin_o", po16, 16'hBEEF);

    // Pins high through reset produce no flag once armed
    tick(1);
    rst = 1'b0;
    tick(8);
    chk_rd(0, XGPIO_IFLAG, 16'h0000, "no_spurious");
    chk_rd(0, XGPIO_DATA,  16'h00FF, "data_ff");
    check("rst_write_dropped", {8'h00, po8}, 16'h0081);

    // W=16: independent lanes, SYNC=3 latency, both-edge mode
    wr(1, WR_UD, XGPIO_DATA, 16'h1234);
    check("ud_only", po16, 16'h12EF);
    wr(1, WR_LD, XGPIO_DATA, 16'h5678);
    check("ld_only", po16, 16'h1278);
    pin16 = 16'h8001;
    tick(3);
    chk_rd(1, XGPIO_IFLAG, 16'h0000, "u16_lat3");
    tick(1);
    chk_rd(1, XGPIO_IFLAG, 16'h8001, "u16_rise");
    wr(1, WR_UD | WR_LD, XGPIO_IFLAG, 16'hFFFF);
    chk_rd(1, XGPIO_IFLAG, 16'h0000, "u16_clear");
    pin16 = 16'h0000;
    tick(4);
    chk_rd(1, XGPIO_IFLAG, 16'h8001, "u16_fall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
